// File: rtl/aes_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | aes_pkg : shared AES-128 constants, schedule FSM states, S-box and Rcon |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
package aes_pkg;

    localparam int AES_NR        = 10;
    localparam int AES_KEY_W     = 128;
    localparam int AES_NUM_RKEYS = AES_NR + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_e;

    // Entry x sits at bits [2047-8x -: 8]; row n covers inputs 16n..16n+15.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX_TABLE[idx -: 8];
    endfunction

    // Counter values outside 1..10 never reach the Keygen; they map to zero.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_schedule_store_keygen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | key_schedule_store_keygen : one combinational AES-128 key-expansion     |
// | round (RotWord, SubWord, Rcon, word XOR chain)                          |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module key_schedule_store_keygen
    import aes_pkg::*;
(
    input  logic [AES_KEY_W-1:0] prev_key_i,
    input  logic [3:0]           reg_counter_i,
    output logic [AES_KEY_W-1:0] next_key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, temp_w;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0     = prev_key_i[127:96];
        w1     = prev_key_i[95:64];
        w2     = prev_key_i[63:32];
        w3     = prev_key_i[31:0];
        rot_w  = {w3[23:0], w3[31:24]};
        temp_w = {sbox(rot_w[31:24]) ^ rcon(reg_counter_i),
                  sbox(rot_w[23:16]),
                  sbox(rot_w[15:8]),
                  sbox(rot_w[7:0])};
        n0 = w0 ^ temp_w;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key_o = {n0, n1, n2, n3};
    end

endmodule
`default_nettype wire

// File: rtl/key_schedule_store.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | key_schedule_store : sequential AES-128 key expansion into an 11-slot   |
// | round-key buffer with a registered, optionally reversed, read port      |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module key_schedule_store
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR,
    parameter bit DEC_ORDER  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AES_KEY_W-1:0] key_in,
    input  logic                 key_valid,
    output logic                 busy,
    output logic                 keys_ready,
    input  logic [3:0]           rd_round,
    output logic [AES_KEY_W-1:0] rd_key
);

    ks_state_e            state_q;
    logic [3:0]           round_cnt_q;
    logic [AES_KEY_W-1:0] work_key_q;
    logic [AES_KEY_W-1:0] slot_q [AES_NUM_RKEYS];
    logic                 busy_q;
    logic                 keys_ready_q;
    logic [AES_KEY_W-1:0] rd_key_q;

    logic [AES_KEY_W-1:0] next_key_w;
    logic [3:0]           rd_idx_w;
    logic [AES_KEY_W-1:0] rd_key_d;

    key_schedule_store_keygen u_keygen (
        .prev_key_i    (work_key_q),
        .reg_counter_i (round_cnt_q),
        .next_key_o    (next_key_w)
    );

    // Subtraction is only consumed when rd_round is in range, so it never underflows.
    if (DEC_ORDER) begin : g_dec_map
        assign rd_idx_w = 4'(NUM_ROUNDS) - rd_round;
    end else begin : g_fwd_map
        assign rd_idx_w = rd_round;
    end

    always_comb begin
        rd_key_d = '0;
        if (keys_ready_q && (rd_round <= 4'(NUM_ROUNDS))) begin
            rd_key_d = slot_q[rd_idx_w];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            round_cnt_q  <= '0;
            work_key_q   <= '0;
            busy_q       <= 1'b0;
            keys_ready_q <= 1'b0;
            rd_key_q     <= '0;
            for (int i = 0; i < AES_NUM_RKEYS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            rd_key_q <= rd_key_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (key_valid) begin
                        slot_q[0]    <= key_in;
                        work_key_q   <= key_in;
                        round_cnt_q  <= 4'd1;
                        busy_q       <= 1'b1;
                        keys_ready_q <= 1'b0;
                        state_q      <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    slot_q[round_cnt_q] <= next_key_w;
                    work_key_q          <= next_key_w;
                    if (round_cnt_q == 4'(NUM_ROUNDS)) begin
                        busy_q       <= 1'b0;
                        keys_ready_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        round_cnt_q <= round_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign keys_ready = keys_ready_q;
    assign rd_key     = rd_key_q;

endmodule
`default_nettype wire
